// File: rtl/sfx_pkg.sv
// Shared sound-effect definitions: sequencer state encoding and default durations.
package sfx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_JUMP      = 3'd1,
    ST_COOLDOWN  = 3'd2,
    ST_DEATH     = 3'd3,
    ST_DEAD_HOLD = 3'd4
  } sfx_state_e;

  localparam int CLKS_PER_MS_DEF = 100000;
  localparam int JUMP_MS_DEF     = 120;
  localparam int COOLDOWN_MS_DEF = 40;
  localparam int DEATH_MS_DEF    = 600;

  // Only the timed states need a target; the others let the timer free-run.
  function automatic logic [15:0] ms_target(sfx_state_e st, logic [15:0] jump_ms,
                                            logic [15:0] cool_ms, logic [15:0] death_ms);
    case (st)
      ST_JUMP:     return jump_ms;
      ST_COOLDOWN: return cool_ms;
      ST_DEATH:    return death_ms;
      default:     return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Game-logic events in, tone-generator requests out.
interface sfx_sequencer_if;
  logic jump_evt;
  logic player_dead;
  logic mute;
  logic jump;
  logic isdead;
  logic busy;

  modport master (output jump_evt, output player_dead, output mute,
                  input jump, input isdead, input busy);
  modport slave  (input jump_evt, input player_dead, input mute,
                  output jump, output isdead, output busy);
endinterface

// File: rtl/sfx_sequencer_ms_timer.sv
// Millisecond prescaler plus ms counter; expired_o pulses combinationally on the
// last cycle of a target-length interval, so clearing on entry gives exact N*CLKS_PER_MS.
module ms_timer #(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic [15:0] target_i,
  output logic        expired_o
);

  localparam logic [16:0] PRESC_LAST = 17'(CLKS_PER_MS - 1);

  logic [16:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic        ms_tick;

  assign ms_tick   = (presc_q == PRESC_LAST);
  assign expired_o = ms_tick && (ms_q == target_i - 16'd1);

  always_comb begin
    presc_d = ms_tick ? 17'd0 : presc_q + 17'd1;
    ms_d    = ms_tick ? ms_q + 16'd1 : ms_q;
    if (clear_i) begin
      presc_d = 17'd0;
      ms_d    = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 17'd0;
      ms_q    <= 16'd0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns jump/death events into exact-length jump/isdead request levels.
// Outputs are registered from the next state, so they move on the same edge as the FSM.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEF,
  parameter int JUMP_MS     = JUMP_MS_DEF,
  parameter int COOLDOWN_MS = COOLDOWN_MS_DEF,
  parameter int DEATH_MS    = DEATH_MS_DEF
) (
  input logic             CLK100MHZ,
  input logic             CPU_RESETN,
  sfx_sequencer_if.slave  bus
);

  sfx_state_e  state_q, state_d;
  logic        jump_q, isdead_q, busy_q, jump_prev_q;
  logic        jump_rise, restart, clear, expired;
  logic [15:0] target;

  assign jump_rise = bus.jump_evt & ~jump_prev_q;
  assign target    = ms_target(state_q, 16'(JUMP_MS), 16'(COOLDOWN_MS), 16'(DEATH_MS));
  assign clear     = (state_d != state_q) || restart;

  ms_timer #(.CLKS_PER_MS(CLKS_PER_MS)) u_timer (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .clear_i   (clear),
    .target_i  (target),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (bus.player_dead && state_q != ST_DEATH && state_q != ST_DEAD_HOLD) begin
      state_d = ST_DEATH;
    end else begin
      case (state_q)
        ST_IDLE:      if (jump_rise) state_d = ST_JUMP;
        ST_JUMP: begin
          if (jump_rise)    restart = 1'b1;
          else if (expired) state_d = (COOLDOWN_MS == 0) ? ST_IDLE : ST_COOLDOWN;
        end
        // A jump edge here is dropped on purpose: no queued jumps.
        ST_COOLDOWN:  if (expired) state_d = ST_IDLE;
        ST_DEATH:     if (expired) state_d = ST_DEAD_HOLD;
        ST_DEAD_HOLD: if (!bus.player_dead) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= ST_IDLE;
      jump_q      <= 1'b0;
      isdead_q    <= 1'b0;
      busy_q      <= 1'b0;
      jump_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      jump_prev_q <= bus.jump_evt;
      jump_q      <= (state_d == ST_JUMP)  && !bus.mute;
      isdead_q    <= (state_d == ST_DEATH) && !bus.mute;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.jump   = jump_q;
  assign bus.isdead = isdead_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Upstream sound-effect sequencer for the game's audio path. It turns game-logic events (jump press, player death) into exact-length `jump` / `isdead` request levels for the downstream tone generator (`audio_engine`). It arbitrates priority (death pre-empts jump), enforces a jump cooldown and holds silence after death until the game restarts. All durations are counted in milliseconds from a prescaled tick.

## Interface
Parameters:
- `CLKS_PER_MS`, default 100000: clock cycles per millisecond tick (100 MHz).
- `JUMP_MS`, default 120: jump-sound length in ms, range 1..65535.
- `COOLDOWN_MS`, default 40: silent gap after a jump sound during which new jumps are ignored, range 0..65535.
- `DEATH_MS`, default 600: death-sound length in ms, range 1..65535.

Ports:
- `CLK100MHZ` in 1: system clock; the only clock.
- `CPU_RESETN` in 1: reset, asynchronous assert, active-low.
- `jump_evt` in 1: jump request level, synchronous to `CLK100MHZ`; only rising edges act.
- `player_dead` in 1: death level, synchronous; high from death until restart.
- `mute` in 1: forces both request outputs low; the FSM keeps running.
- `jump` out 1: jump-sound request to `audio_engine`; registered.
- `isdead` out 1: death-sound request to `audio_engine`; registered.
- `busy` out 1: high in any state other than IDLE; registered.

## Operation
- States:
  - IDLE: no request.
  - JUMP: jump sound playing.
  - COOLDOWN: enforced silence after a jump.
  - DEATH: death sound playing.
  - DEAD_HOLD: silence until restart.
- Edge detect: `jump_rise = jump_evt & ~jump_prev`. `jump_prev` resets to 1, so a level already high at reset does not trigger.
- Transitions, first match wins:
  - Any state except DEATH or DEAD_HOLD, `player_dead`=1 → DEATH. This pre-empts JUMP and COOLDOWN.
  - IDLE, `jump_rise` → JUMP.
  - JUMP, `jump_rise` → JUMP with the timer restarted.
  - JUMP, timer expires → COOLDOWN, or IDLE if `COOLDOWN_MS`=0.
  - COOLDOWN, timer expires → IDLE. `jump_rise` in COOLDOWN is discarded, not queued.
  - DEATH, timer expires → DEAD_HOLD.
  - DEAD_HOLD, `player_dead`=0 → IDLE.
  - DEATH, `player_dead` drops → ignored; DEATH still completes, then DEAD_HOLD exits on the next cycle.
- Timer:
  - Prescaler is 17-bit, counting 0..`CLKS_PER_MS`-1. It emits `ms_tick` on the terminal count.
  - ms counter is 16-bit.
  - Both counters clear on every state entry or restart, so each state lasts exactly N×`CLKS_PER_MS` cycles.
  - Expiry: `ms_tick` while ms count = N-1.
- Outputs:
  - `jump` = (next state is JUMP) & ~`mute`.
  - `isdead` = (next state is DEATH) & ~`mute`.
  - `busy` = (next state is not IDLE).
  - All three are registered, so they change on the same edge as the state register.
  - `mute` therefore takes effect one cycle after it is sampled.
- `jump` and `isdead` are never high together.

## Timing
- Reset (`CPU_RESETN`=0, asynchronous): state IDLE, `jump`=0, `isdead`=0, `busy`=0, both counters 0, `jump_prev`=1.
- Reset mid-sound drops the outputs immediately, without waiting for a clock edge.
- Release is used synchronously: the first active edge is the first rising clock edge after `CPU_RESETN` goes high.
- Latency:
  - `jump_rise` sampled at edge k → `jump`=1 after edge k.
  - `player_dead` sampled at edge k → `isdead`=1 after edge k, and `jump`=0 on the same edge.
- Durations, in cycles:
  - `jump` high for `JUMP_MS`×`CLKS_PER_MS`.
  - COOLDOWN lasts `COOLDOWN_MS`×`CLKS_PER_MS`.
  - `isdead` high for `DEATH_MS`×`CLKS_PER_MS`.
- Simultaneous `jump_rise` and `player_dead` → DEATH wins. The jump edge is lost and `jump_prev` still updates.
- Counters never wrap during valid operation. Parameter ranges guarantee no overflow.

## Structure
- Shared package `sfx_pkg`: state enum localparams (IDLE=0, JUMP=1, COOLDOWN=2, DEATH=3, DEAD_HOLD=4, 3-bit encoding) and the default ms constants. `audio_engine` integration may reuse these.
- Sub-module `ms_timer`: prescaler plus ms counter.
  - Inputs: `clear`, `target`.
  - Output: `expired`, a one-cycle pulse.
  - It is instantiated once.
- The FSM and edge detect live in `sfx_sequencer`.

## Test plan
Test parameters: `CLKS_PER_MS`=4, `JUMP_MS`=3, `COOLDOWN_MS`=2, `DEATH_MS`=5.
1. Reset with `jump_evt` held high, release, wait 40 cycles → `jump`=0, `busy`=0 throughout. Then drop and raise `jump_evt` → `jump` high for exactly 12 cycles, `busy` high 20 cycles.
2. `jump_rise` at cycle 0, second `jump_rise` at cycle 6 → `jump` stays high continuously until cycle 18. A third rise during COOLDOWN → no output.
3. `jump_rise` at cycle 0, `player_dead` at cycle 5 → `jump` falls and `isdead` rises on the same edge. `isdead` stays high 20 cycles, then `busy` stays high until `player_dead`=0, then IDLE one cycle later.
4. `jump_rise` and `player_dead` asserted on the same edge → `isdead`=1, `jump` never asserts.
5. `mute`=1 during a jump → `jump`=0 one cycle later. `busy` and the state timing are unchanged, and the FSM reaches IDLE at cycle 20.
6. `CPU_RESETN` pulsed low mid-DEATH, between edges → `isdead` and `busy` drop asynchronously and the state returns to IDLE.
